load_store_stage: RTL and testbench
===================================

Name: load_store_stage

Overview:
- Memory-access stage between the EX/MEM pipeline register and the MEM/WB register of the 5-stage RISC-V pipeline.
- Accepts ALU results and load/store requests from EX/MEM and drives a variable-latency data-memory port through a req/ready handshake.
- Aligns and sign- or zero-extends load data, and builds byte enables for stores.
- Stalls upstream while an access is outstanding, and presents registered write-back results.

Parameters:
- N, 32, datapath and address width. Only 32 is supported because byte lanes are fixed at 4.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ex_valid  input  1  EX/MEM holds a valid instruction.
- ex_memread  input  1  instruction is a load.
- ex_memwrite  input  1  instruction is a store.
- ex_regwrite  input  1  instruction writes rd.
- ex_funct3  input  3  access size/sign (instruction[14:12]).
- ex_alu  input  N  ALU result; this is the effective address for memory ops.
- ex_wdata  input  N  store data (rs2 after forwarding).
- ex_rd  input  5  destination register.
- stall  output  1  upstream must hold EX/MEM; ex_* is ignored while high.
- mem_req  output  1  data-memory request.
- mem_we  output  1  1 = write.
- mem_addr  output  N  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  output  N  lane-replicated store data.
- mem_be  output  4  byte enables.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_rdata  input  N  read word, valid when mem_ready=1.
- wb_valid  output  1  write-back result valid (one-cycle pulse per instruction).
- wb_regwrite  output  1  write enable toward the register file.
- wb_rd  output  5  destination register.
- wb_data  output  N  ALU result or formatted load data.
- misalign  output  1  misaligned-access flag (exists only with the macro defined).

Behaviour:
- Reset values (async):
  - State is IDLE.
  - All outputs are 0: stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be, wb_valid, wb_regwrite, wb_rd, wb_data, misalign.
- FSM has two states, IDLE and BUSY.
- IDLE, ex_valid=1 and neither memread nor memwrite:
  - On the next edge, wb_valid=1, wb_regwrite=ex_regwrite, wb_rd=ex_rd, wb_data=ex_alu.
  - Latency is 1; state stays IDLE.
- IDLE, ex_valid=1 and memread or memwrite:
  - Capture op, funct3, addr[1:0], rd, regwrite, address and store data.
  - Next state is BUSY; wb_valid=0 that edge.
  - If memread and memwrite are both set, the instruction is treated as a store.
- IDLE, ex_valid=0: wb_valid=0 and all other wb_* outputs hold.
- BUSY:
  - Outputs are registered: stall=1, mem_req=1, and mem_addr/mem_we/mem_be/mem_wdata are stable until the handshake.
  - On an edge with mem_req&mem_ready: next state IDLE, mem_req=0, stall=0, wb_valid=1.
    - Load: wb_data=formatted mem_rdata.
    - Store: wb_regwrite=0 and wb_data=captured address.
  - Minimum memory-op latency is 2 edges from acceptance to wb_valid.
  - stall is low in the cycle after completion, so the next instruction is accepted then.
- stall = (state==BUSY). The instruction presented in the acceptance cycle is consumed; upstream advances once.
- Store formatting:
  - SB (000): be=0001<<a[1:0], wdata={4{b}}.
  - SH (001): be=0011<<{a[1],0}, wdata={2{h}}.
  - SW (010): be=1111.
- Load formatting (lane selected by addr[1:0]):
  - LB (000) / LBU (100): byte, sign- / zero-extended.
  - LH (001) / LHU (101): half selected by a[1], sign- / zero-extended.
  - LW (010): full word.
  - For loads, mem_be=1111.
- funct3 011/110/111 are treated as word accesses.
- Misalignment (macro undefined):
  - Half with a[0]=1 uses a[0] forced to 0.
  - Word with a[1:0]≠0 uses a[1:0] forced to 0.
  - The access completes normally.
- mem_ready while mem_req=0 is ignored.
- Reset asserted mid-access drops mem_req and stall immediately; the access is abandoned with no write-back.

Optional Feature:
- Macro: LOAD_STORE_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned half/word access in IDLE issues no memory request and never enters BUSY.
  - Next edge: wb_valid=1, wb_regwrite=0, wb_data=faulting address, misalign=1 for exactly one cycle.
  - Latency is 1.
- Undefined: the misalign port is absent and forced-alignment behaviour applies.

Test Plan:
1. Reset mid-BUSY (mem_req=1) -> mem_req, stall, wb_valid drop to 0 asynchronously; after release, an ADD with alu=0x10 gives wb_data=0x10 one edge later.
2. ADD rd=5, alu=0x1234 with ex_valid=1 in IDLE -> next edge wb_valid=1, wb_rd=5, wb_data=0x1234, stall stays 0.
3. SB addr=0x103, wdata=0x000000AB, mem_ready high at once -> mem_addr=0x100, be=1000, mem_wdata=0xABABABAB, wb_valid 2 edges after accept, wb_regwrite=0.
4. LB addr=0x202, mem_ready delayed 3 cycles, rdata=0x12F45678 -> stall=1 for 4 cycles, wb_data=0xFFFFFFF4; repeat with LBU -> 0x000000F4.
5. LH addr=0x2 then LHU addr=0x2, rdata=0x8001FFFF -> 0xFFFF8001 then 0x00008001; a back-to-back ALU op behind them is accepted on the cycle stall falls.
6. LW addr=0x101:
   - macro defined -> misalign=1 one cycle, no mem_req, wb_data=0x101, wb_regwrite=0.
   - macro undefined -> mem_addr=0x100, full word returned.

Source files
------------

// File: rtl/load_store_stage.sv
// load_store_stage
//   Memory-access stage of the 5-stage RISC-V pipeline. It sits between the
//   EX/MEM and MEM/WB registers and does the following:
//   - Passes ALU results straight through to write-back with one cycle of latency.
//   - Runs loads and stores over a variable-latency req/ready data-memory port.
//   - Builds byte enables and lane-replicated data for stores.
//   - Aligns and sign- or zero-extends load data.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   ex_*          instruction from EX/MEM; ignored while stall is high
//   stall         upstream must hold EX/MEM (an access is outstanding)
//   mem_*         data-memory request/response port
//   wb_*          registered write-back result; wb_valid is a one-cycle pulse
//   misalign      misaligned-access flag, present only with the macro below
//
// Configuration
//   LOAD_STORE_MISALIGN_TRAP_EN
//   - Defined: a misaligned half or word access issues no memory request.
//     It completes in one cycle with misalign=1 and wb_data=faulting address.
//   - Undefined: the misalign port is absent, and misaligned accesses are
//     forced to natural alignment.
//
// Only N=32 is supported because the byte lanes are fixed at four.
module load_store_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ex_valid,
  input  logic         ex_memread,
  input  logic         ex_memwrite,
  input  logic         ex_regwrite,
  input  logic [2:0]   ex_funct3,
  input  logic [N-1:0] ex_alu,
  input  logic [N-1:0] ex_wdata,
  input  logic [4:0]   ex_rd,
  output logic         stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic [3:0]   mem_be,
  input  logic         mem_ready,
  input  logic [N-1:0] mem_rdata,
  output logic         wb_valid,
  output logic         wb_regwrite,
  output logic [4:0]   wb_rd,
  output logic [N-1:0] wb_data
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
  ,
  output logic         misalign
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t       state_q, state_d;
  logic         is_store_q, is_store_d;
  logic [2:0]   funct3_q, funct3_d;
  logic [1:0]   off_q, off_d;
  logic [4:0]   rd_q, rd_d;
  logic         regwrite_q, regwrite_d;
  logic [N-1:0] addr_q, addr_d;
  logic         mem_we_q, mem_we_d;
  logic [N-1:0] mem_addr_q, mem_addr_d;
  logic [N-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]   mem_be_q, mem_be_d;
  logic         wb_valid_q, wb_valid_d;
  logic         wb_regwrite_q, wb_regwrite_d;
  logic [4:0]   wb_rd_q, wb_rd_d;
  logic [N-1:0] wb_data_q, wb_data_d;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
  logic         misalign_q, misalign_d;
  logic         ex_misaligned;
`endif

  logic         ex_is_mem;
  logic         ex_byte;
  logic         ex_half;
  logic [1:0]   ex_off;
  logic [3:0]   ex_be;
  logic [N-1:0] ex_wfmt;
  logic [7:0]   ld_byte;
  logic [15:0]  ld_half;
  logic [N-1:0] ld_data;

  // Request formatting.
  // - funct3[1:0] picks the access size; 11 falls into the word case.
  // - The lane offset is rounded down to the access size, which gives the
  //   forced-alignment behaviour for misaligned halves and words.
  always_comb begin
    ex_is_mem = ex_memread | ex_memwrite;
    ex_byte   = (ex_funct3[1:0] == 2'b00);
    ex_half   = (ex_funct3[1:0] == 2'b01);
    ex_off    = 2'b00;
    ex_wfmt   = ex_wdata;
    ex_be     = 4'b1111;
    if (ex_byte) begin
      ex_off  = ex_alu[1:0];
      ex_wfmt = {4{ex_wdata[7:0]}};
    end else if (ex_half) begin
      ex_off  = {ex_alu[1], 1'b0};
      ex_wfmt = {2{ex_wdata[15:0]}};
    end
    if (ex_memwrite) begin
      if (ex_byte) begin
        ex_be = 4'b0001 << ex_off;
      end else if (ex_half) begin
        ex_be = 4'b0011 << ex_off;
      end
    end
  end

`ifdef LOAD_STORE_MISALIGN_TRAP_EN
  assign ex_misaligned = (ex_half & ex_alu[0]) |
                         (!ex_byte && !ex_half && (ex_alu[1:0] != 2'b00));
`endif

  // Load formatting from the offset captured at acceptance.
  // funct3[2] selects zero-extension (LBU/LHU).
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   ld_data = funct3_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = funct3_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Next-state and output logic.
  // - The wb_* payload holds between results; only wb_valid (and misalign)
  //   drop back to 0 by default.
  // - When both memread and memwrite are set, memwrite wins.
  always_comb begin
    state_d       = state_q;
    is_store_d    = is_store_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    rd_d          = rd_q;
    regwrite_d    = regwrite_q;
    addr_d        = addr_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    wb_valid_d    = 1'b0;
    wb_regwrite_d = wb_regwrite_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
    misalign_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!ex_is_mem) begin
            wb_valid_d    = 1'b1;
            wb_regwrite_d = ex_regwrite;
            wb_rd_d       = ex_rd;
            wb_data_d     = ex_alu;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
          end else if (ex_misaligned) begin
            wb_valid_d    = 1'b1;
            wb_regwrite_d = 1'b0;
            wb_rd_d       = ex_rd;
            wb_data_d     = ex_alu;
            misalign_d    = 1'b1;
`endif
          end else begin
            state_d     = BUSY;
            is_store_d  = ex_memwrite;
            funct3_d    = ex_funct3;
            off_d       = ex_off;
            rd_d        = ex_rd;
            regwrite_d  = ex_regwrite;
            addr_d      = ex_alu;
            mem_we_d    = ex_memwrite;
            mem_addr_d  = {ex_alu[N-1:2], 2'b00};
            mem_wdata_d = ex_wfmt;
            mem_be_d    = ex_be;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          if (is_store_q) begin
            wb_regwrite_d = 1'b0;
            wb_data_d     = addr_q;
          end else begin
            wb_regwrite_d = regwrite_q;
            wb_data_d     = ld_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state and registered outputs. An async reset abandons any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      is_store_q    <= 1'b0;
      funct3_q      <= 3'd0;
      off_q         <= 2'd0;
      rd_q          <= 5'd0;
      regwrite_q    <= 1'b0;
      addr_q        <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= 4'd0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= '0;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      is_store_q    <= is_store_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      rd_q          <= rd_d;
      regwrite_q    <= regwrite_d;
      addr_q        <= addr_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  assign stall       = (state_q == BUSY);
  assign mem_req     = (state_q == BUSY);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_be      = mem_be_q;
  assign wb_valid    = wb_valid_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
  assign misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_load_store_stage.sv
// Testbench for load_store_stage.
// - Runs directed scenarios first, then randomized instruction streams.
// - The reference model computes lanes, byte enables and extension
//   arithmetically, straight from the load/store rules.
// - The bench plays the data memory itself, with a random ready delay.
module tb_load_store_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_memread = 1'b0;
  logic        ex_memwrite = 1'b0;
  logic        ex_regwrite = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [31:0] ex_alu = 32'd0;
  logic [31:0] ex_wdata = 32'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        wb_valid;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int checkCount = 0;
  int passCount = 0;

  logic [31:0] lastWbData = 32'd0;
  logic [4:0]  lastWbRd = 5'd0;
  logic        lastWbRegwrite = 1'b0;

  load_store_stage #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_regwrite(ex_regwrite), .ex_funct3(ex_funct3), .ex_alu(ex_alu),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_data(wb_data)
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
    ,
    .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference model: access size in bytes from funct3.
  function automatic int unsigned accessSize(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Reference model: byte offset, rounded down to the access size.
  function automatic int unsigned laneOffset(input logic [31:0] addr,
                                             input int unsigned size);
    int unsigned a;
    a = addr % 4;
    return a - (a % size);
  endfunction

  function automatic logic [3:0] expBe(input bit isStore, input logic [2:0] f3,
                                       input logic [31:0] addr);
    int unsigned size;
    int unsigned be;
    if (!isStore) return 4'hF;
    size = accessSize(f3);
    be = ((1 << size) - 1) << laneOffset(addr, size);
    return be[3:0];
  endfunction

  function automatic logic [31:0] expWdata(input logic [2:0] f3,
                                           input logic [31:0] w);
    int unsigned size;
    size = accessSize(f3);
    if (size == 1) return (w & 32'hFF) * 32'h01010101;
    if (size == 2) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] expLoad(input logic [2:0] f3,
                                          input logic [31:0] addr,
                                          input logic [31:0] rdata);
    int unsigned size;
    longint unsigned mask;
    longint unsigned val;
    size = accessSize(f3);
    mask = (64'd1 << (8 * size)) - 1;
    val = ({32'd0, rdata} >> (8 * laneOffset(addr, size))) & mask;
    if (!f3[2] && size < 4 && val >= (mask + 1) / 2) begin
      val = val | (~mask & 64'hFFFFFFFF);
    end
    return val[31:0];
  endfunction

  function automatic bit isMisaligned(input logic [2:0] f3,
                                      input logic [31:0] addr);
    int unsigned size;
    size = accessSize(f3);
    return (size > 1) && ((addr % size) != 0);
  endfunction

  // Presents one instruction at a negedge with stall low.
  // - Plays memory with the given ready delay and checks each cycle.
  // - Returns at the negedge after write-back, where stall is low again.
  task automatic applyStimulus(input bit isLoad, input bit isStore,
                               input logic [2:0] f3, input logic [31:0] alu,
                               input logic [31:0] wdata, input logic [4:0] rd,
                               input bit regwrite, input int delay,
                               input logic [31:0] rdata);
    bit memOp;
    memOp = isLoad | isStore;
    checkOutput("stall_before_accept", stall, 1'b0);
    ex_valid = 1'b1;
    ex_memread = isLoad;
    ex_memwrite = isStore;
    ex_regwrite = regwrite;
    ex_funct3 = f3;
    ex_alu = alu;
    ex_wdata = wdata;
    ex_rd = rd;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
    if (memOp && isMisaligned(f3, alu)) begin
      checkOutput("trap_wb_valid", wb_valid, 1'b1);
      checkOutput("trap_regwrite", wb_regwrite, 1'b0);
      checkOutput("trap_wb_data", wb_data, alu);
      checkOutput("trap_misalign", misalign, 1'b1);
      checkOutput("trap_mem_req", mem_req, 1'b0);
      checkOutput("trap_stall", stall, 1'b0);
      lastWbData = alu; lastWbRd = rd; lastWbRegwrite = 1'b0;
      return;
    end
`endif
    if (!memOp) begin
      checkOutput("alu_wb_valid", wb_valid, 1'b1);
      checkOutput("alu_wb_regwrite", wb_regwrite, regwrite);
      checkOutput("alu_wb_rd", wb_rd, rd);
      checkOutput("alu_wb_data", wb_data, alu);
      checkOutput("alu_stall", stall, 1'b0);
      checkOutput("alu_mem_req", mem_req, 1'b0);
      lastWbData = alu; lastWbRd = rd; lastWbRegwrite = regwrite;
      return;
    end
    for (int c = 0; c <= delay; c++) begin
      checkOutput("busy_stall", stall, 1'b1);
      checkOutput("busy_mem_req", mem_req, 1'b1);
      checkOutput("busy_wb_valid", wb_valid, 1'b0);
      checkOutput("busy_mem_we", mem_we, isStore);
      checkOutput("busy_mem_addr", mem_addr, alu & 32'hFFFFFFFC);
      checkOutput("busy_mem_be", mem_be, expBe(isStore, f3, alu));
      if (isStore) checkOutput("busy_mem_wdata", mem_wdata, expWdata(f3, wdata));
      // Junk on the EX side while stalled must be ignored.
      ex_valid = 1'b1;
      ex_memread = $urandom_range(0, 1);
      ex_memwrite = $urandom_range(0, 1);
      ex_alu = $urandom;
      ex_rd = $urandom;
      mem_ready = (c == delay);
      mem_rdata = (c == delay) ? rdata : $urandom;
      @(posedge clk);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    ex_valid = 1'b0;
    checkOutput("done_wb_valid", wb_valid, 1'b1);
    checkOutput("done_wb_rd", wb_rd, rd);
    checkOutput("done_wb_regwrite", wb_regwrite, isStore ? 1'b0 : regwrite);
    checkOutput("done_wb_data", wb_data, isStore ? alu : expLoad(f3, alu, rdata));
    checkOutput("done_stall", stall, 1'b0);
    checkOutput("done_mem_req", mem_req, 1'b0);
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
    checkOutput("done_misalign", misalign, 1'b0);
`endif
    lastWbData = wb_data;
    lastWbRd = rd;
    lastWbRegwrite = isStore ? 1'b0 : regwrite;
  endtask

  // A cycle with no valid instruction. A stray mem_ready must be ignored,
  // and the wb payload must hold.
  task automatic idleCycle();
    ex_valid = 1'b0;
    ex_memread = $urandom_range(0, 1);
    ex_alu = $urandom;
    mem_ready = $urandom_range(0, 1);
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    checkOutput("idle_wb_valid", wb_valid, 1'b0);
    checkOutput("idle_wb_data_hold", wb_data, lastWbData);
    checkOutput("idle_wb_rd_hold", wb_rd, lastWbRd);
    checkOutput("idle_wb_regwrite_hold", wb_regwrite, lastWbRegwrite);
    checkOutput("idle_mem_req", mem_req, 1'b0);
  endtask

  initial begin
    int kind;
    logic [31:0] rnd;
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_stall", stall, 1'b0);
    checkOutput("reset_mem_req", mem_req, 1'b0);
    checkOutput("reset_mem_we", mem_we, 1'b0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset_mem_be", mem_be, 4'd0);
    checkOutput("reset_wb_valid", wb_valid, 1'b0);
    checkOutput("reset_wb_regwrite", wb_regwrite, 1'b0);
    checkOutput("reset_wb_rd", wb_rd, 5'd0);
    checkOutput("reset_wb_data", wb_data, 32'd0);
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
    checkOutput("reset_misalign", misalign, 1'b0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset during an outstanding access");
    ex_valid = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b0; ex_funct3 = 3'b010;
    ex_alu = 32'h40; ex_rd = 5'd3; ex_regwrite = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    checkOutput("pre_reset_mem_req", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_mem_req", mem_req, 1'b0);
    checkOutput("async_reset_stall", stall, 1'b0);
    checkOutput("async_reset_wb_valid", wb_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    lastWbData = 32'd0; lastWbRd = 5'd0; lastWbRegwrite = 1'b0;
    applyStimulus(0, 0, 3'b000, 32'h10, 32'd0, 5'd1, 1, 0, 32'd0);

    $display("[TB] directed scenarios");
    applyStimulus(0, 0, 3'b000, 32'h1234, 32'd0, 5'd5, 1, 0, 32'd0);
    applyStimulus(0, 1, 3'b000, 32'h103, 32'h000000AB, 5'd7, 1, 0, 32'd0);
    applyStimulus(1, 0, 3'b000, 32'h202, 32'd0, 5'd8, 1, 3, 32'h12F45678);
    applyStimulus(1, 0, 3'b100, 32'h202, 32'd0, 5'd9, 1, 3, 32'h12F45678);
    applyStimulus(1, 0, 3'b001, 32'h2, 32'd0, 5'd10, 1, 1, 32'h8001FFFF);
    applyStimulus(1, 0, 3'b101, 32'h2, 32'd0, 5'd11, 1, 0, 32'h8001FFFF);
    applyStimulus(0, 0, 3'b000, 32'hCAFE, 32'd0, 5'd12, 1, 0, 32'd0);
    applyStimulus(1, 0, 3'b010, 32'h101, 32'd0, 5'd13, 1, 1, 32'hDEADBEEF);
    applyStimulus(1, 1, 3'b001, 32'h301, 32'h0000BEEF, 5'd14, 1, 2, 32'd0);
    idleCycle();

    $display("[TB] randomized instruction stream");
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      rnd = $urandom;
      applyStimulus(kind >= 4 && kind <= 6 || kind == 9, kind >= 7,
                    3'($urandom_range(0, 7)), $urandom, $urandom,
                    5'($urandom_range(0, 31)), bit'(rnd[0]),
                    $urandom_range(0, 3), $urandom);
      if (rnd[3:2] == 2'b00) idleCycle();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
